// File: rtl/fin_period_meter.sv
// Measures the period of the asynchronous reference fin in dco_clk cycles and
// publishes a 2^AVG_LOG2-sample average as the DPLL divide word, with loss-of-reference detection.
module fin_period_meter #(
  parameter int AVG_LOG2    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic        dco_clk,
  input  logic        rst_n,
  input  logic        fin,
  output logic [15:0] fin_w,
  output logic        fin_w_vld,
  output logic        fin_lost
);

  localparam int ACC_W  = 16 + AVG_LOG2;
  localparam int SCNT_W = AVG_LOG2 + 1;
  localparam logic [SCNT_W-1:0] SCNT_FULL = SCNT_W'(1 << AVG_LOG2);
  localparam logic [15:0]       PCNT_SAT  = 16'hFFFF;

  typedef enum logic {
    IDLE,
    MEAS
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               edge_q;
  logic               rise;
  logic [15:0]        pcnt;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_new;
  logic [SCNT_W-1:0]  scnt;
  logic [SCNT_W-1:0]  scnt_new;
  logic               clr_acc;
  logic               add_sample;
  logic               publish;
  logic               timeout;

  always_ff @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], fin};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;

  // Reloading with 1 makes the value seen at the next rise equal the edge-to-edge cycle count.
  always_ff @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (rise) begin
      pcnt <= 16'd1;
    end else if (pcnt != PCNT_SAT) begin
      pcnt <= pcnt + 16'd1;
    end
  end

  always_ff @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Saturation is checked before rise so a coincident edge never yields a 0xFFFF sample.
  always_comb begin
    state_nxt  = state;
    clr_acc    = 1'b0;
    add_sample = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = MEAS;
          clr_acc   = 1'b1;
        end
      end
      MEAS: begin
        if (pcnt == PCNT_SAT) begin
          timeout   = 1'b1;
          clr_acc   = 1'b1;
          state_nxt = IDLE;
        end else if (rise) begin
          add_sample = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign acc_new  = acc + ACC_W'(pcnt);
  assign scnt_new = scnt + SCNT_W'(1);
  assign publish  = add_sample && (scnt_new == SCNT_FULL);

  always_ff @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      scnt      <= '0;
      fin_w     <= '0;
      fin_w_vld <= 1'b0;
      fin_lost  <= 1'b0;
    end else begin
      fin_w_vld <= publish;
      if (clr_acc || publish) begin
        acc  <= '0;
        scnt <= '0;
      end else if (add_sample) begin
        acc  <= acc_new;
        scnt <= scnt_new;
      end
      if (publish) begin
        fin_w <= acc_new[AVG_LOG2 +: 16];
      end
      if (timeout) begin
        fin_lost <= 1'b1;
      end else if (publish) begin
        fin_lost <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fin_period_meter.sv
// Scoreboard bench for fin_period_meter: one averaging (AVG_LOG2=2) and one
// pass-through (AVG_LOG2=0) instance share the same fin stimulus.
module tb_fin_period_meter;

  logic        dco_clk;
  logic        rst_n;
  logic        fin;
  logic [15:0] fin_w_a, fin_w_b;
  logic        fin_w_vld_a, fin_w_vld_b;
  logic        fin_lost_a, fin_lost_b;

  int          n_checks;
  int          n_fail;
  int          cyc;
  int          last_rise;
  int          m_acc[2];
  int          m_scnt[2];
  bit          m_meas[2];
  logic [15:0] exp_q_a[$];
  logic [15:0] exp_q_b[$];
  logic [15:0] exp_a, exp_b;
  int          strobe_cnt_a;
  int          prev_vld_cyc_a, last_vld_cyc_a;
  bit          prev_vld_a;
  bit          in_jitter;
  int          k_rise;

  fin_period_meter #(.AVG_LOG2(2), .SYNC_STAGES(2)) dut_a (
    .dco_clk   (dco_clk),
    .rst_n     (rst_n),
    .fin       (fin),
    .fin_w     (fin_w_a),
    .fin_w_vld (fin_w_vld_a),
    .fin_lost  (fin_lost_a)
  );

  fin_period_meter #(.AVG_LOG2(0), .SYNC_STAGES(2)) dut_b (
    .dco_clk   (dco_clk),
    .rst_n     (rst_n),
    .fin       (fin),
    .fin_w     (fin_w_b),
    .fin_w_vld (fin_w_vld_b),
    .fin_lost  (fin_lost_b)
  );

  initial dco_clk = 1'b0;
  always #5 dco_clk = ~dco_clk;

  initial cyc = 0;
  always @(posedge dco_clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference model: a rise closes the sample opened by the previous rise.
  task automatic modelRise();
    int gap;
    int lg;
    gap = cyc - last_rise;
    for (int i = 0; i < 2; i++) begin
      lg = (i == 0) ? 2 : 0;
      if (m_meas[i] && gap >= 65535) begin
        m_meas[i] = 1'b0;
        if (gap == 65535) continue;
      end
      if (!m_meas[i]) begin
        m_meas[i] = 1'b1;
        m_acc[i]  = 0;
        m_scnt[i] = 0;
      end else begin
        m_acc[i]  += gap;
        m_scnt[i] += 1;
        if (m_scnt[i] == (1 << lg)) begin
          if (i == 0) exp_q_a.push_back(16'(m_acc[i] >> lg));
          else        exp_q_b.push_back(16'(m_acc[i] >> lg));
          m_acc[i]  = 0;
          m_scnt[i] = 0;
        end
      end
    end
    last_rise = cyc;
  endtask

  // Called at a negedge; returns at the negedge exactly `period` cycles later.
  task automatic applyStimulus(input int period);
    fin = 1'b1;
    modelRise();
    repeat (period / 2) @(negedge dco_clk);
    fin = 1'b0;
    repeat (period - period / 2) @(negedge dco_clk);
  endtask

  task automatic doReset();
    checkOutput("sb_drained_a", exp_q_a.size(), 0);
    checkOutput("sb_drained_b", exp_q_b.size(), 0);
    @(negedge dco_clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_fin_w_a", fin_w_a, 0);
    checkOutput("rst_vld_a", fin_w_vld_a, 0);
    checkOutput("rst_lost_a", fin_lost_a, 0);
    checkOutput("rst_fin_w_b", fin_w_b, 0);
    checkOutput("rst_vld_b", fin_w_vld_b, 0);
    checkOutput("rst_lost_b", fin_lost_b, 0);
    @(negedge dco_clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_meas[i] = 1'b0;
      m_acc[i]  = 0;
      m_scnt[i] = 0;
    end
  endtask

  always @(negedge dco_clk) begin
    if (fin_w_vld_a) begin
      checkOutput("sb_pending_a", exp_q_a.size() != 0, 1);
      if (exp_q_a.size() != 0) begin
        exp_a = exp_q_a.pop_front();
        checkOutput("fin_w_a", fin_w_a, exp_a);
      end
      checkOutput("lost_at_vld_a", fin_lost_a, 0);
      checkOutput("vld_back_to_back_a", prev_vld_a, 0);
      if (in_jitter) checkOutput("jitter_range_a", (fin_w_a >= 16'd999) && (fin_w_a <= 16'd1001), 1);
      strobe_cnt_a++;
      prev_vld_cyc_a = last_vld_cyc_a;
      last_vld_cyc_a = cyc;
    end
    if (fin_w_vld_b) begin
      checkOutput("sb_pending_b", exp_q_b.size() != 0, 1);
      if (exp_q_b.size() != 0) begin
        exp_b = exp_q_b.pop_front();
        checkOutput("fin_w_b", fin_w_b, exp_b);
      end
      checkOutput("lost_at_vld_b", fin_lost_b, 0);
    end
    prev_vld_a = fin_w_vld_a;
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    strobe_cnt_a = 0;
    prev_vld_a = 1'b0;
    in_jitter = 1'b0;
    last_rise = 0;
    rst_n = 1'b0;
    fin = 1'b0;
    repeat (3) @(negedge dco_clk);
    doReset();

    $display("[TB] steady period 40");
    repeat (9) applyStimulus(40);
    checkOutput("strobe_spacing_a", last_vld_cyc_a - prev_vld_cyc_a, 160);
    checkOutput("steady_lost_a", fin_lost_a, 0);
    checkOutput("steady_fin_w_a", fin_w_a, 40);

    $display("[TB] alternating and truncating periods");
    doReset();
    applyStimulus(39); applyStimulus(41); applyStimulus(39); applyStimulus(41);
    applyStimulus(10); applyStimulus(10); applyStimulus(10); applyStimulus(11);
    applyStimulus(20);
    checkOutput("trunc_fin_w_a", fin_w_a, 10);

    $display("[TB] unaveraged 100 then 200");
    doReset();
    applyStimulus(100); applyStimulus(200); applyStimulus(20);
    checkOutput("last_fin_w_b", fin_w_b, 200);

    $display("[TB] loss of reference and recovery");
    doReset();
    repeat (4) applyStimulus(40);
    k_rise = cyc;
    applyStimulus(40);
    while (cyc < k_rise + 65537) @(negedge dco_clk);
    checkOutput("lost_early_a", fin_lost_a, 0);
    checkOutput("lost_early_b", fin_lost_b, 0);
    @(negedge dco_clk);
    checkOutput("lost_set_a", fin_lost_a, 1);
    checkOutput("lost_set_b", fin_lost_b, 1);
    checkOutput("lost_hold_fin_w_a", fin_w_a, 40);
    checkOutput("lost_hold_fin_w_b", fin_w_b, 40);
    repeat (4) begin
      applyStimulus(50);
      checkOutput("lost_until_vld_a", fin_lost_a, 1);
    end
    applyStimulus(50);
    checkOutput("lost_cleared_a", fin_lost_a, 0);
    checkOutput("recover_fin_w_a", fin_w_a, 50);

    $display("[TB] reset mid-measurement");
    doReset();
    repeat (7) applyStimulus(40);
    doReset();
    repeat (4) applyStimulus(60);
    checkOutput("post_rst_no_vld_a", fin_w_a, 0);
    applyStimulus(60);
    checkOutput("post_rst_fin_w_a", fin_w_a, 60);

    $display("[TB] jittered period around 1000");
    doReset();
    strobe_cnt_a = 0;
    in_jitter = 1'b1;
    repeat (9) applyStimulus(int'($urandom_range(999, 1001)));
    in_jitter = 1'b0;
    checkOutput("jitter_strobe_count_a", strobe_cnt_a, (9 - 1) / 4);

    repeat (10) @(negedge dco_clk);
    checkOutput("final_drained_a", exp_q_a.size(), 0);
    checkOutput("final_drained_b", exp_q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
